// File: rtl/oled_i2c_responder.sv
// I2C target modelling the OLED controller end of the display link: acknowledges its address,
// decodes page-addressing commands and streams GDDRAM data bytes out as framebuffer writes.
module oled_i2c_responder #(
  parameter logic [6:0] I2C_ADDR = 7'h3C
) (
  input  logic       CLK,
  input  logic       ASYNC_RST_L,
  input  logic       SCL,
  input  logic       SDA_IN,
  output logic       SDA_OE,
  output logic       FB_WE,
  output logic [9:0] FB_ADDR,
  output logic [7:0] FB_DATA,
  output logic       CMD_VALID,
  output logic [7:0] CMD_BYTE,
  output logic       BUSY
);

  typedef enum logic [2:0] {ST_IDLE, ST_ADDR, ST_CTRL, ST_BYTE, ST_IGNORE} state_t;
  typedef enum logic [1:0] {PH_SHIFT, PH_ACK_WAIT, PH_ACK_DRIVE} phase_t;

  state_t r_state, w_state_nxt;
  phase_t r_phase, w_phase_nxt;

  logic r_scl_meta, r_scl_sync, r_scl_prev;
  logic r_sda_meta, r_sda_sync, r_sda_prev;
  logic [2:0] r_bitcnt, w_bitcnt_nxt;
  logic [6:0] r_shift, w_shift_nxt;
  logic       r_sda_oe, w_sda_oe_nxt;
  logic       r_busy, w_busy_nxt;
  logic       r_dc, w_dc_nxt;
  logic       r_arg_pend, w_arg_pend_nxt;
  logic [2:0] r_page, w_page_nxt;
  logic [6:0] r_col, w_col_nxt;
  logic       r_fb_we, w_fb_we_nxt;
  logic [9:0] r_fb_addr, w_fb_addr_nxt;
  logic [7:0] r_fb_data, w_fb_data_nxt;
  logic       r_cmd_valid, w_cmd_valid_nxt;
  logic [7:0] r_cmd_byte, w_cmd_byte_nxt;

  logic       w_scl_rise, w_scl_fall, w_start, w_stop, w_shift_en, w_byte_done, w_addr_ok;
  logic [7:0] w_byte;

  assign w_scl_rise  = r_scl_sync & ~r_scl_prev;
  assign w_scl_fall  = ~r_scl_sync & r_scl_prev;
  assign w_start     = r_scl_sync & r_scl_prev & r_sda_prev & ~r_sda_sync;
  assign w_stop      = r_scl_sync & r_scl_prev & ~r_sda_prev & r_sda_sync;
  assign w_shift_en  = ((r_state == ST_ADDR) || (r_state == ST_CTRL) || (r_state == ST_BYTE)) &&
                       (r_phase == PH_SHIFT) && w_scl_rise;
  assign w_byte_done = w_shift_en && (r_bitcnt == 3'd7);
  assign w_byte      = {r_shift, r_sda_sync};
  assign w_addr_ok   = (w_byte[7:1] == I2C_ADDR) && (w_byte[0] == 1'b0);

  // Flops reset to the idle-bus level so releasing reset never fakes a START or STOP.
  always_ff @(posedge CLK or negedge ASYNC_RST_L) begin
    if (!ASYNC_RST_L) begin
      r_scl_meta <= 1'b1;
      r_scl_sync <= 1'b1;
      r_scl_prev <= 1'b1;
      r_sda_meta <= 1'b1;
      r_sda_sync <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_meta <= SCL;
      r_scl_sync <= r_scl_meta;
      r_scl_prev <= r_scl_sync;
      r_sda_meta <= SDA_IN;
      r_sda_sync <= r_sda_meta;
      r_sda_prev <= r_sda_sync;
    end
  end

  // State register.
  always_ff @(posedge CLK or negedge ASYNC_RST_L) begin
    if (!ASYNC_RST_L) r_state <= ST_IDLE;
    else              r_state <= w_state_nxt;
  end

  // Next-state logic: bus conditions override everything, otherwise advance per completed byte.
  always_comb begin
    w_state_nxt = r_state;
    if (w_start) begin
      w_state_nxt = ST_ADDR;
    end else if (w_stop) begin
      w_state_nxt = ST_IDLE;
    end else if (w_byte_done) begin
      case (r_state)
        ST_ADDR: w_state_nxt = w_addr_ok ? ST_CTRL : ST_IGNORE;
        ST_CTRL: w_state_nxt = ST_BYTE;
        ST_BYTE: w_state_nxt = ST_BYTE;
        default: w_state_nxt = r_state;
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Output/datapath next values: shifting, ACK phasing and the per-byte action.
  always_comb begin
    w_phase_nxt     = r_phase;
    w_bitcnt_nxt    = r_bitcnt;
    w_shift_nxt     = r_shift;
    w_sda_oe_nxt    = r_sda_oe;
    w_busy_nxt      = r_busy;
    w_dc_nxt        = r_dc;
    w_arg_pend_nxt  = r_arg_pend;
    w_page_nxt      = r_page;
    w_col_nxt       = r_col;
    w_fb_we_nxt     = 1'b0;
    w_fb_addr_nxt   = r_fb_addr;
    w_fb_data_nxt   = r_fb_data;
    w_cmd_valid_nxt = 1'b0;
    w_cmd_byte_nxt  = r_cmd_byte;
    if (w_start || w_stop) begin
      w_phase_nxt  = PH_SHIFT;
      w_bitcnt_nxt = 3'd0;
      w_sda_oe_nxt = 1'b0;
      w_busy_nxt   = 1'b0;
    end else if (w_shift_en) begin
      w_shift_nxt  = w_byte[6:0];
      w_bitcnt_nxt = r_bitcnt + 3'd1;
      if (r_bitcnt == 3'd7) begin
        case (r_state)
          ST_ADDR: begin
            if (w_addr_ok) begin
              w_phase_nxt = PH_ACK_WAIT;
              w_busy_nxt  = 1'b1;
            end else begin
              w_busy_nxt  = 1'b0;
            end
          end
          ST_CTRL: begin
            w_phase_nxt = PH_ACK_WAIT;
            w_dc_nxt    = w_byte[6];
          end
          ST_BYTE: begin
            w_phase_nxt = PH_ACK_WAIT;
            if (r_dc) begin
              w_fb_we_nxt   = 1'b1;
              w_fb_addr_nxt = {r_page, r_col};
              w_fb_data_nxt = w_byte;
              w_col_nxt     = r_col + 7'd1;
            end else begin
              w_cmd_valid_nxt = 1'b1;
              w_cmd_byte_nxt  = w_byte;
              if (r_arg_pend) begin
                w_arg_pend_nxt = 1'b0;
              end else if (w_byte[7:4] == 4'h0) begin
                w_col_nxt = {r_col[6:4], w_byte[3:0]};
              end else if (w_byte[7:4] == 4'h1) begin
                w_col_nxt = {w_byte[2:0], r_col[3:0]};
              end else if (w_byte[7:3] == 5'b10110) begin
                w_page_nxt = w_byte[2:0];
              end else if ((w_byte == 8'h20) || (w_byte == 8'h8D) || (w_byte == 8'h81)) begin
                w_arg_pend_nxt = 1'b1;
              end else begin
                w_arg_pend_nxt = r_arg_pend;
              end
            end
          end
          default: w_phase_nxt = r_phase;
        endcase
      end else begin
        w_phase_nxt = r_phase;
      end
    end else if ((r_phase == PH_ACK_WAIT) && w_scl_fall) begin
      w_sda_oe_nxt = 1'b1;
      w_phase_nxt  = PH_ACK_DRIVE;
    end else if ((r_phase == PH_ACK_DRIVE) && w_scl_fall) begin
      w_sda_oe_nxt = 1'b0;
      w_phase_nxt  = PH_SHIFT;
    end else begin
      w_phase_nxt = r_phase;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge CLK or negedge ASYNC_RST_L) begin
    if (!ASYNC_RST_L) begin
      r_phase     <= PH_SHIFT;
      r_bitcnt    <= 3'd0;
      r_shift     <= 7'd0;
      r_sda_oe    <= 1'b0;
      r_busy      <= 1'b0;
      r_dc        <= 1'b0;
      r_arg_pend  <= 1'b0;
      r_page      <= 3'd0;
      r_col       <= 7'd0;
      r_fb_we     <= 1'b0;
      r_fb_addr   <= 10'd0;
      r_fb_data   <= 8'd0;
      r_cmd_valid <= 1'b0;
      r_cmd_byte  <= 8'd0;
    end else begin
      r_phase     <= w_phase_nxt;
      r_bitcnt    <= w_bitcnt_nxt;
      r_shift     <= w_shift_nxt;
      r_sda_oe    <= w_sda_oe_nxt;
      r_busy      <= w_busy_nxt;
      r_dc        <= w_dc_nxt;
      r_arg_pend  <= w_arg_pend_nxt;
      r_page      <= w_page_nxt;
      r_col       <= w_col_nxt;
      r_fb_we     <= w_fb_we_nxt;
      r_fb_addr   <= w_fb_addr_nxt;
      r_fb_data   <= w_fb_data_nxt;
      r_cmd_valid <= w_cmd_valid_nxt;
      r_cmd_byte  <= w_cmd_byte_nxt;
    end
  end

  // A START must release the line in the very cycle it is seen.
  assign SDA_OE    = r_sda_oe & ~w_start;
  assign FB_WE     = r_fb_we;
  assign FB_ADDR   = r_fb_addr;
  assign FB_DATA   = r_fb_data;
  assign CMD_VALID = r_cmd_valid;
  assign CMD_BYTE  = r_cmd_byte;
  assign BUSY      = r_busy;

endmodule

// File: tb/tb_oled_i2c_responder.sv
// Scoreboard bench for oled_i2c_responder: an I2C master drives directed transactions,
// expected strobes are queued up front and a monitor pops/compares them as they appear.
module tb_oled_i2c_responder;
  localparam time Q = 100;

  logic       CLK = 1'b0;
  logic       rst_l;
  logic       scl;
  logic       sda_m;
  logic       sda_line;
  logic       SDA_OE, FB_WE, CMD_VALID, BUSY;
  logic [9:0] FB_ADDR;
  logic [7:0] FB_DATA, CMD_BYTE;

  typedef struct packed {
    logic       is_cmd;
    logic [9:0] addr;
    logic [7:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  assign sda_line = sda_m & ~SDA_OE;

  oled_i2c_responder #(.I2C_ADDR(7'h3C)) dut (
    .CLK(CLK), .ASYNC_RST_L(rst_l), .SCL(scl), .SDA_IN(sda_line), .SDA_OE(SDA_OE),
    .FB_WE(FB_WE), .FB_ADDR(FB_ADDR), .FB_DATA(FB_DATA), .CMD_VALID(CMD_VALID),
    .CMD_BYTE(CMD_BYTE), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every strobe the DUT presents must match the head of the expectation queue.
  always @(negedge CLK) begin
    ev_t e;
    if (FB_WE || CMD_VALID) begin
      chk("strobe_exclusive", 32'(FB_WE & CMD_VALID), 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", {22'd0, FB_ADDR}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("strobe_kind", 32'(CMD_VALID), 32'(e.is_cmd));
        if (FB_WE) begin
          chk("fb_addr", 32'(FB_ADDR), 32'(e.addr));
          chk("fb_data", 32'(FB_DATA), 32'(e.data));
        end else begin
          chk("cmd_byte", 32'(CMD_BYTE), 32'(e.data));
        end
      end
    end
  end

  task automatic push_cmd(input logic [7:0] b);
    exp_q.push_back('{is_cmd: 1'b1, addr: 10'd0, data: b});
  endtask

  task automatic push_fb(input logic [9:0] a, input logic [7:0] b);
    exp_q.push_back('{is_cmd: 1'b0, addr: a, data: b});
  endtask

  task automatic bit_out(input logic b);
    sda_m = b; #Q;
    scl = 1'b1; #(2*Q);
    scl = 1'b0; #Q;
  endtask

  task automatic wbyte(input logic [7:0] b, input logic exp_ack);
    for (int i = 7; i >= 0; i--) bit_out(b[i]);
    sda_m = 1'b1; #Q;
    scl = 1'b1; #Q;
    chk($sformatf("ack_%02h", b), 32'(SDA_OE), 32'(exp_ack));
    #Q;
    scl = 1'b0; #Q;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; #Q;
    scl = 1'b1; #Q;
    sda_m = 1'b0; #Q;
    scl = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; #Q;
    scl = 1'b1; #Q;
    sda_m = 1'b1; #Q;
  endtask

  task automatic data_txn(input logic [7:0] b, input logic [9:0] a);
    i2c_start();
    wbyte(8'h78, 1'b1);
    wbyte(8'h40, 1'b1);
    push_fb(a, b);
    wbyte(b, 1'b1);
    i2c_stop();
  endtask

  initial begin
    logic [7:0] t1_cmds [3];
    logic [7:0] t4_cmds [5];
    logic [7:0] pb;
    t1_cmds = '{8'hB2, 8'h04, 8'h11};
    t4_cmds = '{8'h20, 8'hB3, 8'h81, 8'h05, 8'hAF};
    pb = 8'hF5;

    rst_l = 1'b0; scl = 1'b1; sda_m = 1'b1;
    #50;
    chk("rst_sda_oe", 32'(SDA_OE), 32'd0);
    chk("rst_fb_we", 32'(FB_WE), 32'd0);
    chk("rst_fb_addr", 32'(FB_ADDR), 32'd0);
    chk("rst_fb_data", 32'(FB_DATA), 32'd0);
    chk("rst_cmd_valid", 32'(CMD_VALID), 32'd0);
    chk("rst_cmd_byte", 32'(CMD_BYTE), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    #50;
    rst_l = 1'b1;
    #Q;

    // Page/column commands, then a data write at the resulting address.
    i2c_start();
    wbyte(8'h78, 1'b1);
    chk("busy_after_match", 32'(BUSY), 32'd1);
    wbyte(8'h00, 1'b1);
    foreach (t1_cmds[i]) begin
      push_cmd(t1_cmds[i]);
      wbyte(t1_cmds[i], 1'b1);
    end
    i2c_stop();
    #Q;
    chk("busy_after_stop", 32'(BUSY), 32'd0);
    data_txn(8'hC3, 10'h114);

    // Column 127 wraps to 0 without touching the page.
    i2c_start();
    wbyte(8'h78, 1'b1);
    wbyte(8'h00, 1'b1);
    push_cmd(8'hB0); wbyte(8'hB0, 1'b1);
    push_cmd(8'h0F); wbyte(8'h0F, 1'b1);
    push_cmd(8'h17); wbyte(8'h17, 1'b1);
    i2c_stop();
    i2c_start();
    wbyte(8'h78, 1'b1);
    wbyte(8'h40, 1'b1);
    push_fb(10'h07F, 8'hAA); wbyte(8'hAA, 1'b1);
    push_fb(10'h000, 8'h55); wbyte(8'h55, 1'b1);
    i2c_stop();

    // Wrong address and read requests are ignored entirely.
    i2c_start();
    wbyte(8'h7A, 1'b0);
    chk("busy_wrong_addr", 32'(BUSY), 32'd0);
    wbyte(8'h40, 1'b0);
    wbyte(8'h12, 1'b0);
    i2c_stop();
    i2c_start();
    wbyte(8'h79, 1'b0);
    chk("busy_read", 32'(BUSY), 32'd0);
    wbyte(8'h00, 1'b0);
    wbyte(8'hB5, 1'b0);
    i2c_stop();

    // Argument bytes are strobed but never decoded as commands.
    i2c_start();
    wbyte(8'h78, 1'b1);
    wbyte(8'h00, 1'b1);
    foreach (t4_cmds[i]) begin
      push_cmd(t4_cmds[i]);
      wbyte(t4_cmds[i], 1'b1);
    end
    i2c_stop();
    data_txn(8'h01, 10'h001);
    i2c_start();
    wbyte(8'h78, 1'b1);
    wbyte(8'h00, 1'b1);
    push_cmd(8'hB3); wbyte(8'hB3, 1'b1);
    push_cmd(8'h1A); wbyte(8'h1A, 1'b1);
    i2c_stop();
    data_txn(8'h04, 10'h1A2);

    // Partial bytes cut by STOP or repeated START are dropped.
    i2c_start();
    wbyte(8'h78, 1'b1);
    wbyte(8'h40, 1'b1);
    for (int i = 7; i >= 3; i--) bit_out(pb[i]);
    i2c_stop();
    i2c_start();
    wbyte(8'h78, 1'b1);
    wbyte(8'h40, 1'b1);
    for (int i = 7; i >= 5; i--) bit_out(pb[i]);
    i2c_start();
    wbyte(8'h78, 1'b1);
    chk("busy_after_restart", 32'(BUSY), 32'd1);
    wbyte(8'h40, 1'b1);
    push_fb(10'h1A3, 8'h33);
    wbyte(8'h33, 1'b1);
    i2c_stop();

    // Reset in the middle of an ACK bit.
    i2c_start();
    for (int i = 7; i >= 0; i--) bit_out(pb[i] ^ pb[i] ^ ((8'h78 >> i) & 8'h01) != 8'h00);
    sda_m = 1'b1; #Q;
    scl = 1'b1; #Q;
    chk("ack_before_reset", 32'(SDA_OE), 32'd1);
    rst_l = 1'b0;
    #1;
    chk("reset_sda_oe", 32'(SDA_OE), 32'd0);
    chk("reset_busy", 32'(BUSY), 32'd0);
    #(Q-1);
    rst_l = 1'b1;
    #Q;
    scl = 1'b0; #Q;
    wbyte(8'h40, 1'b0);
    wbyte(8'h55, 1'b0);
    i2c_stop();
    data_txn(8'h99, 10'h000);

    #(20*Q);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/oled_i2c_responder.md
Name: oled_i2c_responder

Overview:
- I2C target that models the OLED controller end of the display link: it receives the command and data stream that the display driver sends over SCL/SDA.
- Acknowledges its own address, parses page-addressing commands, and writes each received GDDRAM data byte into an external 8x128-byte framebuffer port.
- Used on-chip as a display emulator (framebuffer to VGA/debug) and in benches as the self-checking end of the display driver.

Parameters:
- I2C_ADDR, 7'h3C, 7-bit target address to acknowledge.

Ports:
- CLK  in  1  system clock; must be at least 8x the SCL frequency.
- ASYNC_RST_L  in  1  asynchronous active-low reset.
- SCL  in  1  I2C clock, input only.
- SDA_IN  in  1  sampled SDA line.
- SDA_OE  out  1  1 = pull SDA low (ACK); the line is released otherwise.
- FB_WE  out  1  one-CLK framebuffer write strobe.
- FB_ADDR  out  10  {page[2:0], col[6:0]}.
- FB_DATA  out  8  data byte; bit0 is the top pixel row of the page.
- CMD_VALID  out  1  one-CLK strobe per command byte received.
- CMD_BYTE  out  8  command byte, valid with CMD_VALID.
- BUSY  out  1  high from address match until STOP or the next START.

Behaviour:
- Reset values: SDA_OE 0, FB_WE 0, FB_ADDR 0, FB_DATA 0, CMD_VALID 0, CMD_BYTE 0, BUSY 0, page 0, col 0, state IDLE, arg-pending flag 0.
- Reset mid-transfer aborts immediately to IDLE with the line released.
- Synchronisation:
  - SCL and SDA_IN each pass through 2 flops, then one more flop for edge detect.
  - All edges are evaluated on synchronised values.
- Bus conditions:
  - START = SDA falling while SCL high.
  - STOP = SDA rising while SCL high.
  - Both override every state.
  - START (including repeated START) goes to ADDR with the bit count cleared.
  - STOP goes to IDLE.
  - A partial byte is discarded; BUSY drops the cycle after detection.
- Bit shifting: data is sampled on the SCL rising edge, MSB first, 3-bit bit counter.
- ACK timing:
  - On the SCL falling edge after bit 8 of an acknowledged byte, SDA_OE goes to 1.
  - SDA_OE returns to 0 on the next SCL falling edge.
- States:
  - IDLE: waits for START.
  - ADDR: receives 8 bits.
    - Bits[7:1]==I2C_ADDR and R/W==0: ACK, BUSY=1, go to CTRL.
    - Otherwise (mismatch or read): no ACK, go to IGNORE.
  - CTRL: control byte. Bit6 (D/C#) is latched as the mode for the rest of the transaction. Bit7 (Co) is ignored. ACK, then go to BYTE.
  - BYTE: receive 8 bits, ACK, act on the byte, stay in BYTE.
  - IGNORE: no ACK, wait for START/STOP.
- Byte action timing: taken within 2 CLK of the synchronised 8th rising SCL edge, before the ACK is driven.
- Data mode:
  - FB_WE=1 for 1 CLK with FB_ADDR={page,col} and FB_DATA=byte.
  - col then increments; 127 wraps to 0 and page is unchanged (page addressing mode).
- Command mode:
  - CMD_VALID pulses for every byte, arguments included.
  - If arg-pending: the byte is an argument only; clear arg-pending.
  - 8'h00-8'h0F: col[3:0] = byte[3:0].
  - 8'h10-8'h17: col[6:4] = byte[2:0].
  - 8'h18-8'h1F: col[6:4] = byte[2:0]; bit3 is ignored.
  - 8'hB0-8'hB7: page = byte[2:0].
  - 8'h20, 8'h8D, 8'h81: set arg-pending (one argument byte follows).
  - All other commands: strobe only, no state change.
- Persistence: page and col persist across transactions; only reset clears them.
- Strobe ordering: FB_WE and CMD_VALID are never high in the same cycle.
- START while SDA_OE=1: SDA_OE clears on the same cycle as the START is detected.

Test Plan:
- Write 0x78, ctrl 0x00, cmds 0xB2, 0x04, 0x11, STOP -> 3 ACKs after the address; CMD_VALID x3 with bytes B2/04/11; next data write lands at FB_ADDR {2, 0x14} = 10'h114.
- Write 0x78, ctrl 0x40, data 0xAA, 0x55 after page 0 col 127 -> FB_WE twice: ADDR 0x07F data AA, then ADDR 0x000 data 55 (col wrap, page kept).
- Write 0x7A and write 0x79 (read) -> SDA_OE never asserted, BUSY stays 0, no strobes until STOP.
- Cmd 0x20 then 0xB3 -> 0xB3 is consumed as the argument: CMD_VALID x2, page unchanged; next 0xB3 sets page=3.
- STOP after 5 data bits, then repeated-START mid-byte -> no FB_WE for the partial byte; the new address is received correctly and ACKed.
- ASYNC_RST_L low during an ACK bit -> SDA_OE=0 immediately; page/col=0; IDLE ignores bus activity until a fresh START.
